// File: rtl/mtsp_thread_scheduler_if.sv
// rtl/mtsp_thread_scheduler_if.sv - thread command, branch result and issue bus of the MTSP thread scheduler
//
// Purpose: bundles the three streams around the scheduler.
//   cmd_*   : thread start/kill commands (single-cycle strobe, no back-pressure)
//   br_*    : branch-unit results (JMP/ALL/END/SEQ) for the owning thread
//   issue_* : valid/ready offer of one thread PC to fetch
// master = the surrounding core (drives cmd/br, accepts issue), slave = the scheduler.

interface mtsp_thread_scheduler_if #(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 16
);
  localparam int TID_W = $clog2(THREADS);

  logic                cmd_valid;
  logic                cmd_kill;
  logic [TID_W-1:0]    cmd_tid;
  logic [PC_WIDTH-1:0] cmd_pc;

  logic                br_valid;
  logic [TID_W-1:0]    br_tid;
  logic [3:0]          br_op;
  logic [PC_WIDTH-1:0] br_pc;

  logic                issue_valid;
  logic                issue_ready;
  logic [TID_W-1:0]    issue_tid;
  logic [PC_WIDTH-1:0] issue_pc;

  modport master (
    output cmd_valid, cmd_kill, cmd_tid, cmd_pc,
    output br_valid, br_tid, br_op, br_pc,
    output issue_ready,
    input  issue_valid, issue_tid, issue_pc
  );

  modport slave (
    input  cmd_valid, cmd_kill, cmd_tid, cmd_pc,
    input  br_valid, br_tid, br_op, br_pc,
    input  issue_ready,
    output issue_valid, issue_tid, issue_pc
  );
endinterface

// File: rtl/mtsp_thread_scheduler.sv
// rtl/mtsp_thread_scheduler.sv - per-thread PC table and round-robin issue scheduler for the MTSP core
//
// Purpose: holds one PC and one IDLE/READY/INFLIGHT state per hardware thread, starts threads
// from commands, offers READY threads to fetch round-robin, and retires branch results so that
// each thread has at most one instruction in flight.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : cmd_*, br_* inputs; issue_valid/tid/pc offer with issue_ready back-pressure
//   thread_active  : bit i = thread i not IDLE
//   busy           : any thread active
//   err            : sticky protocol error (start on a busy thread, result for a thread not in flight)

module mtsp_thread_scheduler #(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mtsp_thread_scheduler_if.slave bus,
  output logic [THREADS-1:0]   thread_active,
  output logic                 busy,
  output logic                 err
);
  localparam int TID_W = $clog2(THREADS);

  localparam logic [3:0] OP_JMP = 4'd0;
  localparam logic [3:0] OP_ALL = 4'd1;
  localparam logic [3:0] OP_END = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READY    = 2'd1,
    ST_INFLIGHT = 2'd2
  } thr_state_e;

  thr_state_e          state_q [THREADS];
  logic [PC_WIDTH-1:0] pc_q    [THREADS];
  logic [TID_W-1:0]    rr_ptr_q;
  logic                lock_q;
  logic [TID_W-1:0]    lock_tid_q;

  logic                sel_valid;
  logic [TID_W-1:0]    sel_tid;
  logic [TID_W-1:0]    cand;
  logic                handshake;
  logic                kill;

  // Offer selection. A held (not yet accepted) offer is locked so fetch sees a stable TID/PC.
  // Otherwise scan from rr_ptr upward; iterating offsets high-to-low lets the smallest offset,
  // i.e. the first READY thread at or after rr_ptr, be the last and winning assignment.
  always_comb begin
    sel_valid = 1'b0;
    sel_tid   = '0;
    cand      = '0;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_tid   = lock_tid_q;
    end else begin
      for (int i = THREADS - 1; i >= 0; i--) begin
        cand = rr_ptr_q + TID_W'(i);
        if (state_q[cand] == ST_READY) begin
          sel_valid = 1'b1;
          sel_tid   = cand;
        end
      end
    end
  end

  assign bus.issue_valid = sel_valid;
  assign bus.issue_tid   = sel_valid ? sel_tid : '0;
  assign bus.issue_pc    = sel_valid ? pc_q[sel_tid] : '0;

  assign handshake = sel_valid && bus.issue_ready;
  assign kill      = bus.cmd_valid && bus.cmd_kill;

  always_comb begin
    thread_active = '0;
    for (int i = 0; i < THREADS; i++) begin
      thread_active[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign busy = |thread_active;

  // All conditions test the registered state, so a thread written this cycle only becomes
  // visible to selection next cycle. Later assignments in this block win, which gives the start
  // command's PC priority over an ALL fork targeting the same idle thread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < THREADS; i++) begin
        state_q[i] <= ST_IDLE;
        pc_q[i]    <= '0;
      end
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_tid_q <= '0;
      err        <= 1'b0;
    end else if (kill) begin
      for (int i = 0; i < THREADS; i++) begin
        state_q[i] <= ST_IDLE;
      end
      lock_q <= 1'b0;
    end else begin
      if (handshake) begin
        state_q[sel_tid] <= ST_INFLIGHT;
        rr_ptr_q         <= sel_tid + TID_W'(1);
        lock_q           <= 1'b0;
      end else if (sel_valid) begin
        lock_q     <= 1'b1;
        lock_tid_q <= sel_tid;
      end

      // The thread being handed over is READY, so a result naming it cannot be legal;
      // any result for a non-INFLIGHT thread is dropped and flagged.
      if (bus.br_valid) begin
        if (state_q[bus.br_tid] == ST_INFLIGHT) begin
          case (bus.br_op)
            OP_JMP: begin
              pc_q[bus.br_tid]    <= bus.br_pc;
              state_q[bus.br_tid] <= ST_READY;
            end
            OP_END: begin
              state_q[bus.br_tid] <= ST_IDLE;
            end
            OP_ALL: begin
              pc_q[bus.br_tid]    <= bus.br_pc;
              state_q[bus.br_tid] <= ST_READY;
              for (int i = 0; i < THREADS; i++) begin
                if (TID_W'(i) != bus.br_tid && state_q[i] == ST_IDLE) begin
                  pc_q[i]    <= bus.br_pc;
                  state_q[i] <= ST_READY;
                end
              end
            end
            default: begin
              pc_q[bus.br_tid]    <= pc_q[bus.br_tid] + PC_WIDTH'(1);
              state_q[bus.br_tid] <= ST_READY;
            end
          endcase
        end else begin
          err <= 1'b1;
        end
      end

      if (bus.cmd_valid) begin
        if (state_q[bus.cmd_tid] == ST_IDLE) begin
          pc_q[bus.cmd_tid]    <= bus.cmd_pc;
          state_q[bus.cmd_tid] <= ST_READY;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mtsp_thread_scheduler.sv
// tb/tb_mtsp_thread_scheduler.sv - self-checking bench for mtsp_thread_scheduler

module tb_mtsp_thread_scheduler;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] thread_active;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  mtsp_thread_scheduler_if #(.THREADS(T), .PC_WIDTH(16)) bus ();

  mtsp_thread_scheduler #(.THREADS(T), .PC_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .thread_active (thread_active),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = ready, 2 = in flight
  int          m_st [T];
  logic [15:0] m_pc [T];
  int          m_rr;
  bit          m_held;
  int          m_held_tid;
  bit          m_err;

  function automatic void m_reset();
    for (int k = 0; k < T; k++) begin
      m_st[k] = 0;
      m_pc[k] = 16'h0;
    end
    m_rr = 0;
    m_held = 0;
    m_held_tid = 0;
    m_err = 0;
  endfunction

  function automatic void m_offer(output bit v, output int t, output logic [15:0] p);
    v = 0;
    t = 0;
    p = 16'h0;
    if (m_held) begin
      v = 1;
      t = m_held_tid;
    end else begin
      for (int k = 0; k < T; k++) begin
        if (!v && m_st[(m_rr + k) % T] == 1) begin
          v = 1;
          t = (m_rr + k) % T;
        end
      end
    end
    if (v) p = m_pc[t];
  endfunction

  function automatic logic [3:0] m_active();
    logic [3:0] a;
    for (int k = 0; k < T; k++) a[k] = (m_st[k] != 0);
    return a;
  endfunction

  task automatic model_step();
    int st0 [T];
    bit v;
    int t;
    int bt;
    int ct;
    logic [15:0] p;
    if (bus.cmd_valid && bus.cmd_kill) begin
      for (int k = 0; k < T; k++) m_st[k] = 0;
      m_held = 0;
    end else begin
      st0 = m_st;
      m_offer(v, t, p);
      if (v && bus.issue_ready) begin
        m_st[t] = 2;
        m_rr = (t + 1) % T;
        m_held = 0;
      end else if (v) begin
        m_held = 1;
        m_held_tid = t;
      end
      if (bus.br_valid) begin
        bt = int'(bus.br_tid);
        if (st0[bt] != 2) begin
          m_err = 1;
        end else if (bus.br_op == 4'd2) begin
          m_st[bt] = 0;
        end else if (bus.br_op == 4'd0) begin
          m_pc[bt] = bus.br_pc;
          m_st[bt] = 1;
        end else if (bus.br_op == 4'd1) begin
          for (int k = 0; k < T; k++) begin
            if (k == bt || st0[k] == 0) begin
              m_pc[k] = bus.br_pc;
              m_st[k] = 1;
            end
          end
        end else begin
          m_pc[bt] = m_pc[bt] + 16'd1;
          m_st[bt] = 1;
        end
      end
      if (bus.cmd_valid) begin
        ct = int'(bus.cmd_tid);
        if (st0[ct] == 0) begin
          m_pc[ct] = bus.cmd_pc;
          m_st[ct] = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic clear_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_kill  = 1'b0;
    bus.cmd_tid   = '0;
    bus.cmd_pc    = '0;
    bus.br_valid  = 1'b0;
    bus.br_tid    = '0;
    bus.br_op     = '0;
    bus.br_pc     = '0;
  endtask

  // One clock: inputs already driven are sampled at the edge, model follows, strobes drop.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_kill  = 1'b0;
    bus.br_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    bus.issue_ready = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int tid, input logic [15:0] pc);
    bus.cmd_valid = 1'b1;
    bus.cmd_kill  = 1'b0;
    bus.cmd_tid   = 2'(tid);
    bus.cmd_pc    = pc;
    tick();
  endtask

  task automatic branch(input int tid, input logic [3:0] op, input logic [15:0] pc);
    bus.br_valid = 1'b1;
    bus.br_tid   = 2'(tid);
    bus.br_op    = op;
    bus.br_pc    = pc;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.issue_ready = 1'b0;
    m_reset();
    #2;
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.issue_tid !== 2'd0 || bus.issue_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_issue: got valid=%b tid=%0d pc=%h, need 0/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
    checks++;
    if (thread_active !== 4'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got active=%b busy=%b err=%b, need 0000/0/0", thread_active, busy, err);
    end
    do_reset();
  endtask

  task automatic test_single_start();
    bus.issue_ready = 1'b1;
    start(1, 16'h0040);
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'd1 || bus.issue_pc !== 16'h0040) begin
      errors++;
      $display("FAIL start_offer: got valid=%b tid=%0d pc=%h, need 1/1/0040", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
    tick();
    checks++;
    if (bus.issue_valid !== 1'b0 || thread_active !== 4'b0010) begin
      errors++;
      $display("FAIL start_inflight: got valid=%b active=%b, need 0/0010", bus.issue_valid, thread_active);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) start(k, 16'(16 * (k + 1)));
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'(k) || bus.issue_pc !== 16'(16 * (k + 1))) begin
        errors++;
        $display("FAIL rr_order_%0d: got valid=%b tid=%0d pc=%h, need 1/%0d/%h", k, bus.issue_valid, bus.issue_tid, bus.issue_pc, k, 16 * (k + 1));
      end
      tick();
    end
    branch(2, 4'd3, 16'h0);
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'd2 || bus.issue_pc !== 16'h0031) begin
      errors++;
      $display("FAIL rr_seq: got valid=%b tid=%0d pc=%h, need 1/2/0031", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
  endtask

  task automatic test_hold();
    do_reset();
    start(0, 16'h0055);
    start(3, 16'h0077);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'd0 || bus.issue_pc !== 16'h0055) begin
        errors++;
        $display("FAIL hold_%0d: got valid=%b tid=%0d pc=%h, need 1/0/0055", k, bus.issue_valid, bus.issue_tid, bus.issue_pc);
      end
      tick();
    end
    bus.issue_ready = 1'b1;
    tick();
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'd3 || bus.issue_pc !== 16'h0077) begin
      errors++;
      $display("FAIL hold_next: got valid=%b tid=%0d pc=%h, need 1/3/0077", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
  endtask

  task automatic test_fork_all();
    do_reset();
    bus.issue_ready = 1'b1;
    start(0, 16'h0010);
    tick();
    bus.issue_ready = 1'b0;
    branch(0, 4'd1, 16'h0100);
    checks++;
    if (thread_active !== 4'b1111) begin
      errors++;
      $display("FAIL fork_active: got %b, need 1111", thread_active);
    end
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'((k + 1) % 4) || bus.issue_pc !== 16'h0100) begin
        errors++;
        $display("FAIL fork_issue_%0d: got valid=%b tid=%0d pc=%h, need 1/%0d/0100", k, bus.issue_valid, bus.issue_tid, bus.issue_pc, (k + 1) % 4);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) branch(k, 4'd2, 16'h0);
    checks++;
    if (busy !== 1'b0 || thread_active !== 4'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL fork_end: got busy=%b active=%b err=%b, need 0/0000/0", busy, thread_active, err);
    end
  endtask

  task automatic test_wrap_and_errors();
    do_reset();
    bus.issue_ready = 1'b1;
    start(0, 16'hFFFF);
    tick();
    bus.issue_ready = 1'b0;
    branch(0, 4'd3, 16'h0);
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_tid !== 2'd0 || bus.issue_pc !== 16'h0000) begin
      errors++;
      $display("FAIL seq_wrap: got valid=%b tid=%0d pc=%h, need 1/0/0000", bus.issue_valid, bus.issue_tid, bus.issue_pc);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got %b, need 0", err);
    end
    branch(1, 4'd0, 16'h1234);
    checks++;
    if (err !== 1'b1 || thread_active !== 4'b0001 || bus.issue_pc !== 16'h0000) begin
      errors++;
      $display("FAIL br_idle: got err=%b active=%b pc=%h, need 1/0001/0000", err, thread_active, bus.issue_pc);
    end
    start(0, 16'h4444);
    checks++;
    if (err !== 1'b1 || bus.issue_pc !== 16'h0000 || thread_active !== 4'b0001) begin
      errors++;
      $display("FAIL start_busy: got err=%b pc=%h active=%b, need 1/0000/0001", err, bus.issue_pc, thread_active);
    end
  endtask

  task automatic test_kill_and_async_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_kill  = 1'b1;
    tick();
    checks++;
    if (bus.issue_valid !== 1'b0 || thread_active !== 4'b0) begin
      errors++;
      $display("FAIL kill: got valid=%b active=%b, need 0/0000", bus.issue_valid, thread_active);
    end
    bus.issue_ready = 1'b1;
    start(2, 16'h0020);
    tick();
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.issue_pc !== 16'h0 || thread_active !== 4'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b pc=%h active=%b busy=%b err=%b, need all 0", bus.issue_valid, bus.issue_pc, thread_active, busy, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    branch(2, 4'd2, 16'h0);
    checks++;
    if (err !== 1'b1 || thread_active !== 4'b0) begin
      errors++;
      $display("FAIL stale_result: got err=%b active=%b, need 1/0000", err, thread_active);
    end
  endtask

  task automatic test_random();
    bit v;
    int t;
    int cand;
    logic [15:0] p;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      m_offer(v, t, p);
      checks++;
      if (bus.issue_valid !== v) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %b, need %b", n, bus.issue_valid, v);
      end
      if (v) begin
        checks++;
        if (bus.issue_tid !== 2'(t) || bus.issue_pc !== p) begin
          errors++;
          $display("FAIL rnd_offer@%0d: got tid=%0d pc=%h, need %0d/%h", n, bus.issue_tid, bus.issue_pc, t, p);
        end
      end
      checks++;
      if (thread_active !== m_active() || err !== m_err) begin
        errors++;
        $display("FAIL rnd_status@%0d: got active=%b err=%b, need %b/%b", n, thread_active, err, m_active(), m_err);
      end
      bus.issue_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_kill  = ($urandom_range(0, 29) == 0);
        bus.cmd_tid   = 2'($urandom_range(0, 3));
        bus.cmd_pc    = 16'($urandom);
      end
      if ($urandom_range(0, 9) < 4) begin
        cand = $urandom_range(0, 3);
        for (int k = 0; k < T; k++) begin
          if (m_st[(cand + k) % T] == 2 && m_st[cand] != 2) cand = (cand + k) % T;
        end
        bus.br_valid = 1'b1;
        bus.br_tid   = 2'(cand);
        bus.br_op    = 4'($urandom_range(0, 5));
        bus.br_pc    = 16'($urandom);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_start();
    test_round_robin();
    test_hold();
    test_fork_all();
    test_wrap_and_errors();
    test_kill_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
